// File: rtl/gate_pkg.sv
// Shared types and constants for the noise gate: envelope states, switch
// thresholds and the gain format.
package gate_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    ATTACK  = 2'd1,
    OPEN    = 2'd2,
    RELEASE = 2'd3
  } gate_state_t;

  localparam int GAIN_W = 5;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 5'd16;

  localparam logic [10:0] THR_LOW  = 11'd64;
  localparam logic [10:0] THR_MID  = 11'd128;
  localparam logic [10:0] THR_HIGH = 11'd256;

  function automatic logic [10:0] threshold_of(input logic [1:0] amount);
    case (amount)
      2'b01:   return THR_LOW;
      2'b10:   return THR_MID;
      2'b11:   return THR_HIGH;
      default: return 11'd0;
    endcase
  endfunction

endpackage

// File: rtl/noise_gate_envelope.sv
// Gate envelope: state machine, hold/release counters and the 0..16 gain,
// advanced once per accepted sample.
module noise_gate_envelope
  import gate_pkg::*;
#(
  parameter int HOLD_SAMPLES = 1200,
  parameter int RELEASE_DIV  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              above,
  input  logic              bypass,
  output logic [GAIN_W-1:0] gain,
  output logic              gate_open
);

  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam int RW = $clog2(RELEASE_DIV + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES);
  localparam logic [RW-1:0] REL_LOAD  = RW'(RELEASE_DIV);

  gate_state_t   state;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rel_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      rel_cnt   <= '0;
      gate_open <= 1'b0;
    end else if (valid) begin
      if (bypass) begin
        state     <= OPEN;
        gain      <= GAIN_UNITY;
        hold_cnt  <= HOLD_LOAD;
        gate_open <= 1'b1;
      end else begin
        case (state)
          CLOSED: begin
            // The opening sample already gets the first attack step.
            if (above) begin
              state     <= ATTACK;
              gain      <= 5'd1;
              hold_cnt  <= HOLD_LOAD;
              gate_open <= 1'b1;
            end
          end
          ATTACK: begin
            if (above) hold_cnt <= HOLD_LOAD;
            if (gain >= GAIN_UNITY - 5'd1) begin
              gain  <= GAIN_UNITY;
              state <= OPEN;
            end else begin
              gain <= gain + 5'd1;
            end
          end
          OPEN: begin
            if (above) begin
              hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt <= HW'(1)) begin
              hold_cnt <= '0;
              rel_cnt  <= REL_LOAD;
              state    <= RELEASE;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          RELEASE: begin
            // Re-attack continues from the current gain to avoid a step.
            if (above) begin
              hold_cnt <= HOLD_LOAD;
              state    <= ATTACK;
            end else if (rel_cnt <= RW'(1)) begin
              rel_cnt <= REL_LOAD;
              gain    <= gain - 5'd1;
              if (gain <= 5'd1) begin
                state     <= CLOSED;
                rel_cnt   <= '0;
                gate_open <= 1'b0;
              end
            end else begin
              rel_cnt <= rel_cnt - RW'(1);
            end
          end
          default: begin
            state     <= CLOSED;
            gain      <= '0;
            gate_open <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/noise_gate_module.sv
// Downward expander / noise gate on signed 12-bit samples with a ready/done
// handshake and two cycles of latency.
module noise_gate_module
  import gate_pkg::*;
#(
  parameter int SAMPLING_RATE = 24000,
  parameter int HOLD_MS       = 50,
  parameter int RELEASE_DIV   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic [11:0] incoming_sample,
  input  logic [1:0]  gate_amount,
  output logic [11:0] modified_sample,
  output logic        done,
  output logic        gate_open
);

  localparam int HOLD_SAMPLES = SAMPLING_RATE * HOLD_MS / 1000;

  logic [10:0]        mag;
  logic               above;
  logic               bypass;
  logic [GAIN_W-1:0]  gain;
  logic [11:0]        sample_q;
  logic               valid_q;
  logic signed [15:0] product;
  logic signed [11:0] scaled;

  // -2048 has no positive twin, so its magnitude saturates to 2047.
  always_comb begin
    if (!incoming_sample[11]) begin
      mag = incoming_sample[10:0];
    end else if (incoming_sample == 12'h800) begin
      mag = 11'h7FF;
    end else begin
      mag = ~incoming_sample[10:0] + 11'd1;
    end
  end

  assign bypass = (gate_amount == 2'b00);
  assign above  = (mag >= threshold_of(gate_amount));

  noise_gate_envelope #(
    .HOLD_SAMPLES(HOLD_SAMPLES),
    .RELEASE_DIV (RELEASE_DIV)
  ) u_envelope (
    .clock    (clock),
    .reset    (reset),
    .valid    (ready),
    .above    (above),
    .bypass   (bypass),
    .gain     (gain),
    .gate_open(gate_open)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      valid_q <= ready;
      if (ready) sample_q <= incoming_sample;
    end
  end

  // Gain register already holds this sample's update; the shift floors.
  assign product = $signed({{4{sample_q[11]}}, sample_q}) * $signed({11'd0, gain});
  assign scaled  = 12'(product >>> 4);

  always_ff @(posedge clock) begin
    if (reset) begin
      done            <= 1'b0;
      modified_sample <= '0;
    end else begin
      done <= valid_q;
      if (valid_q) modified_sample <= scaled;
    end
  end

endmodule

// File: tb/tb_noise_gate_module.sv
// Self-checking bench: directed tables and sequences plus random traffic,
// all scored against a sample-by-sample behavioural gate model.
module tb_noise_gate_module;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready;
  logic [11:0] incoming_sample;
  logic [1:0]  gate_amount;
  logic [11:0] modified_sample;
  logic        done;
  logic        gate_open;

  always #5 clock = ~clock;

  noise_gate_module dut (
    .clock          (clock),
    .reset          (reset),
    .ready          (ready),
    .incoming_sample(incoming_sample),
    .gate_amount    (gate_amount),
    .modified_sample(modified_sample),
    .done           (done),
    .gate_open      (gate_open)
  );

  typedef struct { bit v; bit hc; int out; int hexp; } slot_t;
  typedef struct { int x; int ga; int exp; } vec_t;

  localparam int PH_CLOSED = 0, PH_ATTACK = 1, PH_OPEN = 2, PH_RELEASE = 3;
  localparam int HOLD = 1200, REL = 64;

  slot_t p0, p1;
  int vectors = 0;
  int miscompares = 0;
  int exp_mod = 0;
  int m_ph = PH_CLOSED, m_g = 0, m_hold = 0, m_rel = 0;

  // One accepted sample through the reference gate; returns the output value.
  function automatic int model_sample(input int x, input int ga);
    int mag, thr;
    bit above;
    mag = (x < 0) ? -x : x;
    if (mag > 2047) mag = 2047;
    thr = (ga == 1) ? 64 : (ga == 2) ? 128 : 256;
    above = (mag >= thr);
    if (ga == 0) begin
      m_ph = PH_OPEN; m_g = 16; m_hold = HOLD;
    end else if (m_ph == PH_CLOSED) begin
      if (above) begin m_ph = PH_ATTACK; m_g = 1; m_hold = HOLD; end
    end else if (m_ph == PH_ATTACK) begin
      if (above) m_hold = HOLD;
      m_g = m_g + 1;
      if (m_g >= 16) begin m_g = 16; m_ph = PH_OPEN; end
    end else if (m_ph == PH_OPEN) begin
      if (above) m_hold = HOLD;
      else begin
        m_hold = m_hold - 1;
        if (m_hold == 0) begin m_ph = PH_RELEASE; m_rel = REL; end
      end
    end else begin
      if (above) begin m_ph = PH_ATTACK; m_hold = HOLD; end
      else begin
        m_rel = m_rel - 1;
        if (m_rel == 0) begin
          m_g = m_g - 1; m_rel = REL;
          if (m_g == 0) m_ph = PH_CLOSED;
        end
      end
    end
    return (x * m_g) >>> 4;
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle at the falling edge, then score the slot whose done is due.
  task automatic step(input bit rst, input bit rdy, input int x, input int ga,
                      input bit hc, input int hexp);
    slot_t e;
    reset = rst; ready = rdy; incoming_sample = 12'(x); gate_amount = 2'(ga);
    e.v = 1'b0; e.hc = hc; e.hexp = hexp; e.out = 0;
    if (rst) begin
      p0.v = 1'b0; exp_mod = 0;
      m_ph = PH_CLOSED; m_g = 0; m_hold = 0; m_rel = 0;
    end else if (rdy) begin
      e.v = 1'b1; e.out = model_sample(x, ga);
    end
    @(negedge clock);
    p1 = p0; p0 = e;
    check("done", int'(done), int'(p1.v));
    if (p1.v) begin
      exp_mod = p1.out;
      if (p1.hc) check("directed", int'($signed(modified_sample)), p1.hexp);
    end
    check("modified_sample", int'($signed(modified_sample)), exp_mod);
    check("gate_open", int'(gate_open), (m_ph != PH_CLOSED) ? 1 : 0);
  endtask

  vec_t tbl_bypass [0:2] = '{'{300, 0, 300}, '{-2048, 0, -2048}, '{2047, 0, 2047}};
  vec_t tbl_low [0:8] = '{'{-63, 1, 0}, '{-64, 1, -4}, '{1000, 1, 125},
                          '{1000, 1, 187}, '{1000, 1, 250}, '{1000, 1, 312},
                          '{1000, 1, 375}, '{1000, 1, 437}, '{-1, 1, -1}};

  initial begin
    int ga_r, x_r;
    bit rst_r, rdy_r;
    p0 = '{v: 1'b0, hc: 1'b0, out: 0, hexp: 0};
    p1 = p0;

    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Bypass: output equals input, two cycles after ready.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, tbl_bypass[i].x, tbl_bypass[i].ga, 1'b1, tbl_bypass[i].exp);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);

    // Threshold 256: quiet samples silenced, then attack, hold and release.
    step(1'b1, 1'b0, 0, 3, 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 100, 3, 1'b1, 0);
    for (int k = 1; k <= 16; k++) step(1'b0, 1'b1, 1000, 3, 1'b1, (1000 * k) >>> 4);
    for (int i = 0; i < 1200 + 63; i++) step(1'b0, 1'b1, 10, 3, 1'b1, 10);
    step(1'b0, 1'b1, 10, 3, 1'b1, 9);
    step(1'b0, 1'b1, 300, 3, 1'b1, 281);
    step(1'b0, 1'b1, 300, 3, 1'b1, 300);
    step(1'b0, 1'b0, 0, 3, 1'b0, 0);
    step(1'b0, 1'b0, 0, 3, 1'b0, 0);

    // Threshold 64 boundary and floor of small negative products.
    step(1'b1, 1'b0, 0, 1, 1'b0, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, tbl_low[i].x, tbl_low[i].ga, 1'b1, tbl_low[i].exp);
    step(1'b0, 1'b0, 0, 1, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1, 1'b0, 0);

    // Reset right after ready discards the in-flight sample.
    step(1'b0, 1'b1, 500, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);

    ga_r = 3;
    for (int i = 0; i < 4000; i++) begin
      rst_r = ($urandom_range(0, 499) == 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) ga_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) x_r = int'($urandom_range(0, 600)) - 300;
      else x_r = int'($urandom_range(0, 4095)) - 2048;
      step(rst_r, rdy_r, x_r, ga_r, 1'b0, 0);
    end
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
